product_accumulator: RTL and testbench

Sequential accumulate stage directly downstream of the 3x3 Wallace-tree multiplier. It consumes one product per valid/ready handshake and sums a fixed group of TERMS products into a registered accumulator. It then presents the group total on a valid/ready output port, so a dot product can be built from the combinational multiplier's output stream.

---
 rtl/product_acc_pkg.sv | 5 +
 rtl/product_accumulator_if.sv | 16 +
 rtl/acc_sat_add.sv | 16 +
 rtl/product_accumulator.sv | 51 +++++
 tb/tb_product_accumulator.sv | 143 ++++++++++++++
 5 files changed

// File: rtl/product_acc_pkg.sv
// product_acc_pkg: shared state encoding and term width for product_accumulator (saturation via ACC_SATURATE_EN).
package product_acc_pkg;
  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_e;
  localparam int PROD_W = 7;
endpackage

// File: rtl/product_accumulator_if.sv
// product_accumulator_if: term input, result output and flush bundle; master drives terms, slave is the accumulator.
interface product_accumulator_if import product_acc_pkg::*; #(parameter int ACC_W = 12);
  logic flush;
  logic in_valid;
  logic in_ready;
  logic [PROD_W-2:0] product;
  logic product_cout;
  logic out_valid;
  logic out_ready;
  logic [ACC_W-1:0] acc_out;
  logic overflow;
  modport master (output flush, in_valid, product, product_cout, out_ready,
                  input in_ready, out_valid, acc_out, overflow);
  modport slave (input flush, in_valid, product, product_cout, out_ready,
                 output in_ready, out_valid, acc_out, overflow);
endinterface

// File: rtl/acc_sat_add.sv
// acc_sat_add: accumulator + term adder with carry; clamps to all-ones when ACC_SATURATE_EN is defined, wraps otherwise.
module acc_sat_add import product_acc_pkg::*; #(parameter int ACC_W = 12) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] term,
  output logic [ACC_W-1:0]  sum,
  output logic              carry
);
  logic [ACC_W:0] raw;
  assign raw = {1'b0, acc} + (ACC_W+1)'(term);
  assign carry = raw[ACC_W];
`ifdef ACC_SATURATE_EN
  assign sum = carry ? '1 : raw[ACC_W-1:0];
`else
  assign sum = raw[ACC_W-1:0];
`endif
endmodule

// File: rtl/product_accumulator.sv
// product_accumulator: sums TERMS multiplier products per result behind valid/ready ports.
// Wrap vs clamp on overflow selected by ACC_SATURATE_EN in acc_sat_add.
module product_accumulator import product_acc_pkg::*; #(
  parameter int TERMS = 8,
  parameter int ACC_W = 12
) (
  input logic clk,
  input logic rst_n,
  product_accumulator_if.slave b
);
  localparam int CW = $clog2(TERMS);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d, sum;
  logic ovf_q, ovf_d, carry;
  logic acc_fire, out_fire, clr, last;
  acc_sat_add #(.ACC_W(ACC_W)) u_add (
    .acc(acc_q),
    .term({b.product_cout, b.product}),
    .sum(sum),
    .carry(carry)
  );
  assign acc_fire = state_q == ACCUM && b.in_valid;
  assign out_fire = state_q == HOLD && b.out_ready;
  assign clr = b.flush || out_fire;
  assign last = cnt_q == CW'(TERMS - 1);
  // flush outranks any handshake offered in the same cycle
  always_comb begin
    state_d = clr ? ACCUM : (acc_fire && last) ? HOLD : state_q;
    acc_d = clr ? '0 : acc_fire ? sum : acc_q;
    cnt_d = clr ? '0 : acc_fire ? cnt_q + CW'(1) : cnt_q;
    ovf_d = clr ? 1'b0 : acc_fire ? ovf_q | carry : ovf_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end
  assign b.in_ready = state_q == ACCUM;
  assign b.out_valid = state_q == HOLD;
  assign b.acc_out = acc_q;
  assign b.overflow = ovf_q;
endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator: drives a 12-bit and an 8-bit accumulator in lockstep and checks both against a sum-based model.
module tb_product_accumulator;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  product_accumulator_if #(.ACC_W(12)) ia();
  product_accumulator_if #(.ACC_W(8)) ib();
  product_accumulator #(.TERMS(8), .ACC_W(12)) dut_a (.clk(clk), .rst_n(rst_n), .b(ia));
  product_accumulator #(.TERMS(8), .ACC_W(8)) dut_b (.clk(clk), .rst_n(rst_n), .b(ib));
  always #5 clk = ~clk;
  logic [25:0] obs;
  assign obs = {ia.in_ready, ia.out_valid, ia.overflow, ia.acc_out,
                ib.in_ready, ib.out_valid, ib.overflow, ib.acc_out};
  // expected observation for both widths given the true unbounded running sum
  function automatic logic [25:0] model(input bit rdy, input bit vld, input int s);
    int ra, rb;
    bit oa, ob;
    oa = s > 4095;
    ob = s > 255;
`ifdef ACC_SATURATE_EN
    ra = oa ? 4095 : s;
    rb = ob ? 255 : s;
`else
    ra = s % 4096;
    rb = s % 256;
`endif
    return {rdy, vld, oa, 12'(ra), rdy, vld, ob, 8'(rb)};
  endfunction
  task automatic drive(input bit fl, input bit iv, input int v, input bit ordy);
    ia.flush = fl; ib.flush = fl;
    ia.in_valid = iv; ib.in_valid = iv;
    ia.product = v[5:0]; ib.product = v[5:0];
    ia.product_cout = v[6]; ib.product_cout = v[6];
    ia.out_ready = ordy; ib.out_ready = ordy;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // gap: 0 none, 1 every other cycle, 2 random
  task automatic send_group(input int v[8], input int gap, input int bp, input string nm);
    int s = 0;
    logic [25:0] e;
    for (int i = 0; i < 8; i++) begin
      if (gap == 1 || (gap == 2 && $urandom_range(0, 1) == 1)) begin
        drive(0, 0, int'($urandom_range(0, 127)), bp == 0);
        step();
        e = model(1, 0, s);
        n_tests++;
        if (obs !== e) begin n_fail++; $display("FAIL %s gap%0d got %h exp %h", nm, i, obs, e); end
      end
      drive(0, 1, v[i], bp == 0);
      step();
      s += v[i];
      e = model(i != 7, i == 7, s);
      n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL %s term%0d got %h exp %h", nm, i, obs, e); end
    end
    for (int k = 0; k < bp; k++) begin
      drive(0, int'($urandom_range(0, 1)), int'($urandom_range(0, 127)), 0);
      step();
      e = model(0, 1, s);
      n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL %s hold%0d got %h exp %h", nm, k, obs, e); end
    end
    drive(0, 0, 0, 1);
    step();
    e = model(1, 0, 0);
    n_tests++;
    if (obs !== e) begin n_fail++; $display("FAIL %s drain got %h exp %h", nm, obs, e); end
    drive(0, 0, 0, 0);
  endtask
  task automatic test_reset();
    drive(0, 0, 0, 0);
    rst_n = 0;
    step();
    step();
    rst_n = 1;
    step();
    n_tests++;
    if (obs !== model(1, 0, 0)) begin n_fail++; $display("FAIL reset got %h exp %h", obs, model(1, 0, 0)); end
  endtask
  task automatic test_basic();
    int v[8];
    foreach (v[i]) v[i] = 49;
    send_group(v, 0, 0, "basic49");
  endtask
  task automatic test_backpressure();
    int v[8];
    foreach (v[i]) v[i] = i + 1;
    send_group(v, 0, 5, "backpressure");
  endtask
  task automatic test_abort(input bit use_rst, input string nm);
    int v[8];
    for (int i = 0; i < 3; i++) begin drive(0, 1, 10, 0); step(); end
    n_tests++;
    if (obs !== model(1, 0, 30)) begin n_fail++; $display("FAIL %s partial got %h exp %h", nm, obs, model(1, 0, 30)); end
    drive(!use_rst, 1, 100, 1);
    rst_n = !use_rst;
    step();
    rst_n = 1;
    n_tests++;
    if (obs !== model(1, 0, 0)) begin n_fail++; $display("FAIL %s cleared got %h exp %h", nm, obs, model(1, 0, 0)); end
    foreach (v[i]) v[i] = 1;
    send_group(v, 0, 0, nm);
  endtask
  task automatic test_flush_hold();
    for (int i = 0; i < 8; i++) begin drive(0, 1, 127, 0); step(); end
    n_tests++;
    if (obs !== model(0, 1, 1016)) begin n_fail++; $display("FAIL flush_hold full got %h exp %h", obs, model(0, 1, 1016)); end
    drive(1, 1, 5, 1);
    step();
    n_tests++;
    if (obs !== model(1, 0, 0)) begin n_fail++; $display("FAIL flush_hold cleared got %h exp %h", obs, model(1, 0, 0)); end
    drive(0, 0, 0, 0);
  endtask
  task automatic test_gapped();
    int v[8];
    foreach (v[i]) v[i] = 7;
    send_group(v, 1, 0, "gapped");
  endtask
  task automatic test_random();
    int v[8];
    for (int g = 0; g < 12; g++) begin
      foreach (v[i]) v[i] = int'($urandom_range(0, 127));
      send_group(v, 2, int'($urandom_range(0, 3)), "random");
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_abort(0, "flush");
    test_abort(1, "rst_mid");
    test_flush_hold();
    test_gapped();
    test_random();
    test_basic();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
